weight_stream_ctrl: RTL and testbench

WEIGHT_STREAM_CTRL -- requirements
Module: weight_stream_ctrl

---
 rtl/weight_stream_pkg.sv | 15 +
 rtl/weight_stream_fifo.sv | 56 +++++
 rtl/weight_stream_ctrl.sv | 152 +++++++++++++++
 tb/tb_weight_stream_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_stream_pkg.sv
// Shared types and helpers for the weight stream controller.
package weight_stream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain
  } state_e;

  // Output FIFO depth needed so that every in-flight ROM read always has a slot.
  function automatic int unsigned fifo_depth(input int unsigned rom_latency);
    return rom_latency + 2;
  endfunction

endpackage

// File: rtl/weight_stream_fifo.sv
// Synchronous register FIFO; head entry is the registered output, count includes it.
module weight_stream_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d, wr_idx;
  logic             valid_q, valid_d, pop;

  // Next-state: shift down on pop, then write behind the last occupied entry.
  always_comb begin
    pop    = valid_q && rd_ready;
    wr_idx = count_q - CNT_W'(pop);
    for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];
    if (pop) begin
      for (int i = 0; i + 1 < int'(DEPTH); i++) mem_d[i] = mem_q[i + 1];
    end
    if (wr_en) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wr_idx == CNT_W'(i)) mem_d[i] = wr_data;
      end
    end
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    valid_d = (count_d != '0);
  end

  // Storage, occupancy and registered valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data  = mem_q[0];
  assign rd_valid = valid_q;
  assign count    = count_q;

endmodule

// File: rtl/weight_stream_ctrl.sv
// Streams DEPTH ROM words per pass, num_passes times, into a credit-limited output FIFO.
// Optional stall counter port enabled by WEIGHT_STREAM_CTRL_STALL_COUNT_EN.
module weight_stream_ctrl
  import weight_stream_pkg::*;
#(
  parameter int unsigned DEPTH       = 576,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned ROM_LATENCY = 2,
  parameter int unsigned PASS_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
`ifdef WEIGHT_STREAM_CTRL_STALL_COUNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int unsigned FIFO_DEPTH = fifo_depth(ROM_LATENCY);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [PASS_WIDTH-1:0]  pass_q, pass_d;
  logic [PASS_WIDTH-1:0]  np_q, np_d;
  logic                   done_q, done_d;
  logic [ROM_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [CNT_W-1:0]       inflight, fifo_count;
  logic [CNT_W:0]         used;
  logic                   issue, credit, xfer;

  // Words issued to the ROM that have not yet landed in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(ROM_LATENCY); i++) inflight = inflight + CNT_W'(vld_sr_q[i]);
  end

  assign used   = (CNT_W + 1)'(inflight) + (CNT_W + 1)'(fifo_count);
  assign credit = used < (CNT_W + 1)'(FIFO_DEPTH);
  assign xfer   = data_out_valid && data_out_ready;

  // Next-state, address/pass counters and issue decision.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    np_d    = np_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          np_d   = num_passes;
          addr_d = '0;
          pass_d = '0;
          if (num_passes == '0) done_d = 1'b1;
          else                  state_d = StStream;
        end
      end
      StStream: begin
        if (credit) begin
          issue = 1'b1;
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            pass_d = pass_q + PASS_WIDTH'(1);
            if (pass_q == np_q - PASS_WIDTH'(1)) state_d = StDrain;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      StDrain: begin
        // Last word leaves the FIFO with nothing left in the ROM pipeline.
        if (inflight == '0 && fifo_count == CNT_W'(1) && xfer) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    vld_sr_d = (vld_sr_q << 1) | ROM_LATENCY'(issue);
  end

  // Control state register; reset aborts any job and flushes the read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      pass_q   <= '0;
      np_q     <= '0;
      done_q   <= 1'b0;
      vld_sr_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pass_q   <= pass_d;
      np_q     <= np_d;
      done_q   <= done_d;
      vld_sr_q <= vld_sr_d;
    end
  end

  weight_stream_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_WIDTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_sr_q[ROM_LATENCY-1]),
    .wr_data (rom_q),
    .rd_ready(data_out_ready),
    .rd_data (data_out),
    .rd_valid(data_out_valid),
    .count   (fifo_count)
  );

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign rom_addr = addr_q;
  assign rom_ce   = 1'b1;

`ifdef WEIGHT_STREAM_CTRL_STALL_COUNT_EN
  logic [31:0] stall_q;

  // Saturating count of back-pressured valid cycles, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == StIdle && start) begin
      stall_q <= '0;
    end else if (data_out_valid && !data_out_ready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Self-checking bench for weight_stream_ctrl (DEPTH=8, ROM latency 2).
module tb_weight_stream_ctrl;

  localparam int AW = 4;
  localparam int DW = 128;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [PW-1:0] num_passes;
  logic          busy, done, rom_ce;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q, data_out;
  logic          data_out_valid, data_out_ready;
`ifdef WEIGHT_STREAM_CTRL_STALL_COUNT_EN
  logic [31:0]   stall_cycles;
`endif

  weight_stream_ctrl #(.DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_passes    (num_passes),
    .busy          (busy),
    .done          (done),
    .rom_addr      (rom_addr),
    .rom_ce        (rom_ce),
    .rom_q         (rom_q),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
`ifdef WEIGHT_STREAM_CTRL_STALL_COUNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {4{28'h1234567, a}};
  endfunction

  // Two-cycle ROM: address registered, then data registered.
  logic [AW-1:0] rom_a1;
  always @(posedge clk) begin
    if (rom_ce) rom_a1 <= rom_addr;
    rom_q <= rom_word(rom_a1);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: expected words in delivery order, plus observed stream statistics.
  logic [DW-1:0] exp_q[$];
  bit            mon_en = 0;
  int            beats, done_cnt, done_cyc, last_beat_cyc, stall_obs, max_cnt, start_cyc;
  bit            busy_seen, hold_pending, addr_moved;
  logic [DW-1:0] held;

  task automatic clear_stats();
    exp_q.delete();
    beats = 0; done_cnt = 0; done_cyc = 0; last_beat_cyc = 0; stall_obs = 0; max_cnt = 0;
    busy_seen = 0; hold_pending = 0; addr_moved = 0;
  endtask

  task automatic load_model(input int np);
    for (int p = 0; p < np; p++)
      for (int a = 0; a < 8; a++) exp_q.push_back(rom_word(AW'(a)));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
      if (busy) busy_seen = 1;
      if (rom_addr != '0) addr_moved = 1;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (hold_pending) begin
        check("hold_valid", DW'(data_out_valid), DW'(1));
        check("hold_data", data_out, held);
      end
      hold_pending = data_out_valid && !data_out_ready;
      if (hold_pending) begin held = data_out; stall_obs++; end
      if (data_out_valid && data_out_ready) begin
        beats++;
        last_beat_cyc = cyc;
        check("beat_expected", DW'(exp_q.size() != 0), DW'(1));
        if (exp_q.size() != 0) check("beat_data", data_out, exp_q.pop_front());
      end
    end
  end

  function automatic logic ready_for(input int mode, input int stall, input int rel);
    if (rel < stall) return 1'b0;
    if (mode == 0) return 1'b1;
    if (mode == 1) return (rel % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_job(input int np, input int mode, input int stall, input int restart,
                         input int exp_beats, input int exp_stall);
    int post;
    post = -1;
    clear_stats();
    load_model(np);
    mon_en = 1;
    start = 1; num_passes = PW'(np); data_out_ready = ready_for(mode, stall, 0);
    start_cyc = cyc;
    step();
    for (int rel = 1; rel < 3000; rel++) begin
      data_out_ready = ready_for(mode, stall, rel);
      if (rel == restart) begin start = 1; num_passes = 8'd7; end
      else begin start = 0; num_passes = PW'(np); end
      if (stall >= 10 && np > 0 && rel == stall - 1) check("credit_hold_addr", DW'(rom_addr), DW'(4));
      step();
      if (done_cnt > 0 && post < 0) post = rel;
      if (post >= 0 && rel >= post + 3) break;
    end
    start = 0; data_out_ready = 1;
    check("job_done_in_time", DW'(done_cnt > 0), DW'(1));
    check("beats", DW'(beats), DW'(exp_beats));
    check("model_drained", DW'(exp_q.size()), DW'(0));
    check("done_once", DW'(done_cnt), DW'(1));
    if (np == 0) begin
      check("zero_done_at_1", DW'(done_cyc - start_cyc), DW'(1));
      check("zero_busy_never", DW'(busy_seen), DW'(0));
      check("zero_addr_still", DW'(addr_moved), DW'(0));
    end else begin
      check("done_after_last", DW'(done_cyc), DW'(last_beat_cyc + 1));
    end
    check("fifo_count_le_4", DW'(max_cnt <= 4), DW'(1));
    check("idle_after", DW'(busy), DW'(0));
    check("addr_after", DW'(rom_addr), DW'(0));
`ifdef WEIGHT_STREAM_CTRL_STALL_COUNT_EN
    check("stall_vs_observed", DW'(stall_cycles), DW'(stall_obs));
    if (exp_stall >= 0) check("stall_expected", DW'(stall_cycles), DW'(exp_stall));
`endif
    mon_en = 0;
  endtask

  typedef struct {
    int np;
    int mode;       // 0 ready high, 1 toggling, 2 random
    int stall;      // ready forced low for this many cycles from start
    int restart;    // cycle to pulse start while busy (0 = never)
    int exp_beats;
    int exp_stall;  // -1 = only compare with observation
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{np: 1, mode: 0, stall: 0,  restart: 0,  exp_beats: 8,  exp_stall: 0};
    vecs[1] = '{np: 3, mode: 1, stall: 0,  restart: 0,  exp_beats: 24, exp_stall: -1};
    vecs[2] = '{np: 1, mode: 0, stall: 20, restart: 0,  exp_beats: 8,  exp_stall: 16};
    vecs[3] = '{np: 0, mode: 0, stall: 0,  restart: 0,  exp_beats: 0,  exp_stall: 0};
    vecs[4] = '{np: 2, mode: 0, stall: 0,  restart: 10, exp_beats: 16, exp_stall: 0};
    vecs[5] = '{np: 4, mode: 2, stall: 3,  restart: 0,  exp_beats: 32, exp_stall: -1};

    // Reset values.
    rst = 1; start = 0; num_passes = '0; data_out_ready = 0;
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_valid", DW'(data_out_valid), DW'(0));
    check("rst_data", data_out, DW'(0));
    check("rst_addr", DW'(rom_addr), DW'(0));
    check("rst_ce", DW'(rom_ce), DW'(1));
`ifdef WEIGHT_STREAM_CTRL_STALL_COUNT_EN
    check("rst_stall", DW'(stall_cycles), DW'(0));
`endif
    step();
    rst = 0;
    step();

    // Reset during beat 3 of 8 aborts the job.
    clear_stats(); load_model(1); mon_en = 1;
    start = 1; num_passes = 8'd1; data_out_ready = 1;
    step();
    start = 0;
    for (int g = 0; g < 50 && beats < 3; g++) step();
    check("abort_reach_beat3", DW'(beats), DW'(3));
    rst = 1; mon_en = 0;
    step();
    rst = 0;
    @(negedge clk);
    check("abort_valid", DW'(data_out_valid), DW'(0));
    check("abort_busy", DW'(busy), DW'(0));
    check("abort_addr", DW'(rom_addr), DW'(0));
    clear_stats(); mon_en = 1;
    repeat (15) step();
    check("abort_no_beats", DW'(beats), DW'(0));
    check("abort_no_done", DW'(done_cnt), DW'(0));
    mon_en = 0;

    // Exact cycle timing of a single pass with ready held high.
    clear_stats(); load_model(1); mon_en = 1;
    start = 1; num_passes = 8'd1; data_out_ready = 1;
    step();
    start = 0;
    for (int rel = 1; rel <= 13; rel++) begin
      @(negedge clk);
      if (rel <= 8) check("t_addr", DW'(rom_addr), DW'(rel - 1));
      check("t_valid", DW'(data_out_valid), DW'(rel >= 4 && rel <= 11));
      check("t_busy", DW'(busy), DW'(rel <= 11));
      check("t_done", DW'(done), DW'(rel == 12));
      step();
    end
    check("t_beats", DW'(beats), DW'(8));
    check("t_drained", DW'(exp_q.size()), DW'(0));
    mon_en = 0;

    for (int v = 0; v < 6; v++)
      run_job(vecs[v].np, vecs[v].mode, vecs[v].stall, vecs[v].restart,
              vecs[v].exp_beats, vecs[v].exp_stall);

    for (int k = 0; k < 8; k++) begin
      int np;
      np = int'($urandom_range(0, 4));
      run_job(np, 2, int'($urandom_range(0, 15)), 0, 8 * np, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
